// File: rtl/target_encoder.sv
// Purpose : small fully-associative table that encodes a branch target into a short index,
//           allocating a new entry on a miss when asked; the decode side reads it back.
// Latency : accept at edge E0, response after edge E(k+1) for a hit at k, E(n+1) for a
//           miss/allocation with n valid entries, E(DEPTH) for FULL.
// Backpr. : one request in flight; Req_ready is low from accept until the response is
//           taken (Rsp_valid && Rsp_ready). The response is held stable while Rsp_ready is low.
//
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-low reset
//   Clear               synchronous invalidate of every entry (honoured only when idle)
//   Req_valid/ready     request handshake; Req_target is the offset to look up,
//                       Req_alloc asks for a new entry when the target is absent
//   Rsp_valid/ready     response handshake; Rsp_addr is the index, Rsp_status is
//                       00 HIT, 01 NEW, 10 MISS, 11 FULL
//   Rd_addr, Rd_target  combinational decode of an index (DFLT for an invalid entry)
//   Count               number of valid entries, 0..DEPTH

module target_encoder #(
  parameter int              DEPTH = 8,
  parameter int              AW    = 3,
  parameter int              TW    = 10,
  parameter logic [TW-1:0]   DFLT  = 10'h001
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          Req_valid,
  output logic          Req_ready,
  input  logic [TW-1:0] Req_target,
  input  logic          Req_alloc,
  output logic          Rsp_valid,
  input  logic          Rsp_ready,
  output logic [AW-1:0] Rsp_addr,
  output logic [1:0]    Rsp_status,
  input  logic [AW-1:0] Rd_addr,
  output logic [TW-1:0] Rd_target,
  output logic [AW:0]   Count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0]    ST_HIT  = 2'b00;
  localparam logic [1:0]    ST_NEW  = 2'b01;
  localparam logic [1:0]    ST_MISS = 2'b10;
  localparam logic [1:0]    ST_FULL = 2'b11;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       req_tgt_q, req_tgt_d;
  logic                req_alloc_q, req_alloc_d;
  logic [AW-1:0]       rsp_addr_q, rsp_addr_d;
  logic [1:0]          rsp_status_q, rsp_status_d;
  logic [AW:0]         count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [TW-1:0]       tgt_q [DEPTH];
  logic [TW-1:0]       tgt_d [DEPTH];

  // Entries are allocated contiguously from index 0, so the first invalid
  // entry met during the linear scan is both the miss point and the next
  // free slot; no separate free pointer is needed.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    req_tgt_d    = req_tgt_q;
    req_alloc_d  = req_alloc_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_status_d = rsp_status_q;
    count_d      = count_q;
    valid_d      = valid_q;
    tgt_d        = tgt_q;

    unique case (state_q)
      IDLE: begin
        // Clear wins over a simultaneous request, which stays pending.
        if (Clear) begin
          valid_d = '0;
          count_d = '0;
        end else if (Req_valid) begin
          req_tgt_d   = Req_target;
          req_alloc_d = Req_alloc;
          idx_d       = '0;
          state_d     = SEARCH;
        end
      end

      SEARCH: begin
        if (valid_q[idx_q]) begin
          if (tgt_q[idx_q] == req_tgt_q) begin
            rsp_status_d = ST_HIT;
            rsp_addr_d   = idx_q;
            state_d      = RESP;
          end else if (idx_q == LAST_IDX) begin
            rsp_status_d = ST_FULL;
            rsp_addr_d   = '0;
            state_d      = RESP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (req_alloc_q) begin
          // Written on the same edge that enters RESP, so the new entry is
          // readable in the cycle Rsp_valid rises.
          tgt_d[idx_q]   = req_tgt_q;
          valid_d[idx_q] = 1'b1;
          count_d        = count_q + CNT_ONE;
          rsp_status_d   = ST_NEW;
          rsp_addr_d     = idx_q;
          state_d        = RESP;
        end else begin
          rsp_status_d = ST_MISS;
          rsp_addr_d   = '0;
          state_d      = RESP;
        end
      end

      RESP: begin
        if (Rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      req_tgt_q    <= '0;
      req_alloc_q  <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_status_q <= ST_HIT;
      count_q      <= '0;
      valid_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tgt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      req_tgt_q    <= req_tgt_d;
      req_alloc_q  <= req_alloc_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_status_q <= rsp_status_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        tgt_q[i] <= tgt_d[i];
      end
    end
  end

  assign Req_ready  = (state_q == IDLE) && !Clear;
  assign Rsp_valid  = (state_q == RESP);
  assign Rsp_addr   = rsp_addr_q;
  assign Rsp_status = rsp_status_q;
  assign Count      = count_q;
  assign Rd_target  = valid_q[Rd_addr] ? tgt_q[Rd_addr] : DFLT;

  // Count is a cached popcount of the valid bits and never exceeds DEPTH.
  a_count_range : assert property (@(posedge Clk) disable iff (!Reset)
    count_q <= (AW+1)'(DEPTH));
  a_count_pop : assert property (@(posedge Clk) disable iff (!Reset)
    count_q == (AW+1)'($countones(valid_q)));
  // A stalled response does not change underneath the consumer.
  a_rsp_stable : assert property (@(posedge Clk) disable iff (!Reset)
    (state_q == RESP && !Rsp_ready) |=>
      (state_q == RESP && $stable(rsp_addr_q) && $stable(rsp_status_q)));

endmodule

// File: tb/tb_target_encoder.sv
module tb_target_encoder;

  logic       Clk;
  logic       Reset;
  logic       Clear;
  logic       Req_valid;
  logic       Req_ready;
  logic [9:0] Req_target;
  logic       Req_alloc;
  logic       Rsp_valid;
  logic       Rsp_ready;
  logic [2:0] Rsp_addr;
  logic [1:0] Rsp_status;
  logic [2:0] Rd_addr;
  logic [9:0] Rd_target;
  logic [3:0] Count;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] HIT  = 2'b00;
  localparam logic [1:0] NEW  = 2'b01;
  localparam logic [1:0] MISS = 2'b10;
  localparam logic [1:0] FULL = 2'b11;

  typedef struct {
    logic [9:0] tgt;
    bit         alloc;
    logic [1:0] st;
    logic [2:0] addr;
    int         lat;
    int         cnt;
    int         hold;
    bit         clr;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [2:0] addr;
    int         lat;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];

  target_encoder #(.DEPTH(8), .AW(3), .TW(10), .DFLT(10'h001)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Clear      (Clear),
    .Req_valid  (Req_valid),
    .Req_ready  (Req_ready),
    .Req_target (Req_target),
    .Req_alloc  (Req_alloc),
    .Rsp_valid  (Rsp_valid),
    .Rsp_ready  (Rsp_ready),
    .Rsp_addr   (Rsp_addr),
    .Rsp_status (Rsp_status),
    .Rd_addr    (Rd_addr),
    .Rd_target  (Rd_target),
    .Count      (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_dflt(input string nm);
    for (int i = 0; i < 8; i++) begin
      Rd_addr = 3'(i);
      #1;
      chk(nm, Rd_target, 10'h001);
    end
  endtask

  // Caller is positioned 1ns after a rising edge with the DUT idle.
  task automatic do_req(input logic [9:0] t, input bit a, input logic [1:0] st,
                        input logic [2:0] ad, input int lat, input int cnt,
                        input int hold, input bit clr);
    exp_t e;
    exp_t got;
    int   n;
    chk("req_ready_idle", Req_ready, 1);
    Req_target = t;
    Req_alloc  = a;
    Req_valid  = 1'b1;
    e.st = st; e.addr = ad; e.lat = lat; e.cnt = cnt;
    sb.push_back(e);
    got = e;
    @(posedge Clk); #1;
    Req_valid = 1'b0;
    n = 0;
    while (!Rsp_valid && n < 30) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("rsp_valid_seen", Rsp_valid, 1);
    if (sb.size() > 0) got = sb.pop_front();
    chk("rsp_latency", n, got.lat);
    chk("rsp_status", Rsp_status, got.st);
    chk("rsp_addr", Rsp_addr, got.addr);
    chk("count_at_rsp", Count, got.cnt);
    if (st == NEW) begin
      Rd_addr = ad;
      #1;
      chk("rd_target_new", Rd_target, t);
    end
    for (int h = 0; h < hold; h++) begin
      Clear = clr;
      @(posedge Clk); #1;
      chk("hold_valid", Rsp_valid, 1);
      chk("hold_addr", Rsp_addr, got.addr);
      chk("hold_status", Rsp_status, got.st);
      chk("hold_req_ready", Req_ready, 0);
    end
    Clear     = 1'b0;
    Rsp_ready = 1'b1;
    @(posedge Clk); #1;
    Rsp_ready = 1'b0;
    chk("rsp_drop", Rsp_valid, 0);
    chk("count_after", Count, got.cnt);
  endtask

  initial begin
    // tgt, alloc, status, addr, latency, count, hold, clear-during-hold
    vecs[0]  = '{10'h3fd, 1'b1, NEW,  3'd0, 1, 1, 0, 1'b0};
    vecs[1]  = '{10'h3fb, 1'b1, NEW,  3'd1, 2, 2, 0, 1'b0};
    vecs[2]  = '{10'h003, 1'b1, NEW,  3'd2, 3, 3, 0, 1'b0};
    vecs[3]  = '{10'h007, 1'b1, NEW,  3'd3, 4, 4, 0, 1'b0};
    vecs[4]  = '{10'h007, 1'b0, HIT,  3'd3, 4, 4, 5, 1'b1};
    vecs[5]  = '{10'h005, 1'b0, MISS, 3'd0, 5, 4, 0, 1'b0};
    vecs[6]  = '{10'h3fd, 1'b0, HIT,  3'd0, 1, 4, 0, 1'b0};
    vecs[7]  = '{10'h3fb, 1'b1, HIT,  3'd1, 2, 4, 0, 1'b0};
    vecs[8]  = '{10'h1fd, 1'b0, MISS, 3'd0, 5, 4, 0, 1'b0};
    vecs[9]  = '{10'h1fd, 1'b1, NEW,  3'd4, 5, 5, 0, 1'b0};
    vecs[10] = '{10'h100, 1'b1, NEW,  3'd5, 6, 6, 2, 1'b0};
    vecs[11] = '{10'h200, 1'b1, NEW,  3'd6, 7, 7, 0, 1'b0};
    vecs[12] = '{10'h000, 1'b1, NEW,  3'd7, 8, 8, 0, 1'b0};
    vecs[13] = '{10'h155, 1'b1, FULL, 3'd0, 8, 8, 3, 1'b1};
    vecs[14] = '{10'h000, 1'b0, HIT,  3'd7, 8, 8, 0, 1'b0};
    vecs[15] = '{10'h2aa, 1'b0, FULL, 3'd0, 8, 8, 0, 1'b0};

    Reset = 1'b0; Clear = 1'b0; Req_valid = 1'b0; Req_target = '0;
    Req_alloc = 1'b0; Rsp_ready = 1'b0; Rd_addr = 3'd3;
    #1;
    chk("reset_rd_target", Rd_target, 10'h001);
    chk("reset_count", Count, 0);
    chk("reset_req_ready", Req_ready, 1);
    chk("reset_rsp_valid", Rsp_valid, 0);
    chk("reset_rsp_addr", Rsp_addr, 0);
    chk("reset_rsp_status", Rsp_status, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk_all_dflt("empty_rd_target");
    @(posedge Clk); #1;

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].tgt, vecs[i].alloc, vecs[i].st, vecs[i].addr,
             vecs[i].lat, vecs[i].cnt, vecs[i].hold, vecs[i].clr);
    end

    // Table contents after fill, read through the decode port.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].st == NEW || i >= 9) begin
        // rows 0..3 and 9..12 allocated entries 0..7 in order
      end
    end
    begin
      logic [9:0] fill [8];
      fill = '{10'h3fd, 10'h3fb, 10'h003, 10'h007, 10'h1fd, 10'h100, 10'h200, 10'h000};
      for (int i = 0; i < 8; i++) begin
        Rd_addr = 3'(i);
        #1;
        chk("rd_target_full", Rd_target, fill[i]);
      end
    end
    @(posedge Clk); #1;

    // Clear together with a request in IDLE: Clear wins, request not taken.
    Clear = 1'b1; Req_valid = 1'b1; Req_target = 10'h3fd; Req_alloc = 1'b1;
    #1;
    chk("clear_req_ready", Req_ready, 0);
    @(posedge Clk); #1;
    Clear = 1'b0; Req_valid = 1'b0;
    chk("clear_count", Count, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      chk("clear_no_rsp", Rsp_valid, 0);
      chk("clear_idle_ready", Req_ready, 1);
    end
    chk_all_dflt("clear_rd_target");
    @(posedge Clk); #1;
    do_req(10'h3fd, 1'b1, NEW, 3'd0, 1, 1, 0, 1'b0);
    do_req(10'h111, 1'b1, NEW, 3'd1, 2, 2, 0, 1'b0);
    do_req(10'h222, 1'b1, NEW, 3'd2, 3, 3, 0, 1'b0);

    // Reset in the middle of an allocating search.
    Req_target = 10'h333; Req_alloc = 1'b1; Req_valid = 1'b1;
    @(posedge Clk); #1;
    Req_valid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", Rsp_valid, 0);
    chk("midrst_count", Count, 0);
    chk("midrst_req_ready", Req_ready, 1);
    chk("midrst_rsp_addr", Rsp_addr, 0);
    chk("midrst_rsp_status", Rsp_status, 0);
    chk_all_dflt("midrst_rd_target");
    @(posedge Clk); #2;
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      chk("postrst_no_rsp", Rsp_valid, 0);
    end
    chk("postrst_count", Count, 0);
    do_req(10'h3fb, 1'b1, NEW, 3'd0, 1, 1, 0, 1'b0);
    do_req(10'h3fb, 1'b0, HIT, 3'd0, 1, 1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
